// File: rtl/letc_core_limp_axi_bridge.sv
// LIMP-to-AXI4 bridge: each LIMP request becomes one single-beat AXI4 read or write.
// Sub-word writes are lane-shifted with strobes; sub-word reads are right-justified and zero-extended.
`timescale 1ns/1ps
module letc_core_limp_axi_bridge #(
  parameter int PADDR_W = 34
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_limp_valid,
  output logic               o_limp_ready,
  input  logic               i_limp_wen_nren,
  input  logic               i_limp_uncacheable,
  input  logic [1:0]         i_limp_size,
  input  logic [PADDR_W-1:0] i_limp_addr,
  output logic [31:0]        o_limp_rdata,
  input  logic [31:0]        i_limp_wdata,
  output logic               o_awvalid,
  input  logic               i_awready,
  output logic [PADDR_W-1:0] o_awaddr,
  output logic               o_wvalid,
  input  logic               i_wready,
  output logic [31:0]        o_wdata,
  output logic [3:0]         o_wstrb,
  input  logic               i_bvalid,
  output logic               o_bready,
  input  logic [1:0]         i_bresp,
  output logic               o_arvalid,
  input  logic               i_arready,
  output logic [PADDR_W-1:0] o_araddr,
  input  logic               i_rvalid,
  output logic               o_rready,
  input  logic [31:0]        i_rdata,
  input  logic [1:0]         i_rresp,
  output logic               o_bus_error
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_e;

  state_e             state_q, state_d;
  logic [PADDR_W-1:0] addr_q, addr_d;
  logic [1:0]         size_q, size_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [1:0]         resp_q, resp_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;

  logic [4:0]         lane_shift;
  logic [31:0]        rdata_shifted;
  logic [31:0]        rdata_fmt;
  logic [3:0]         wstrb_raw;
  logic [PADDR_W-1:0] addr_aligned;
  logic               unused_uncacheable;

  assign unused_uncacheable = i_limp_uncacheable;
  assign lane_shift         = {addr_q[1:0], 3'b000};
  assign addr_aligned       = {addr_q[PADDR_W-1:2], 2'b00};
  assign rdata_shifted      = rdata_q >> lane_shift;

  always_comb begin
    case (size_q)
      2'd0:    rdata_fmt = {24'd0, rdata_shifted[7:0]};
      2'd1:    rdata_fmt = {16'd0, rdata_shifted[15:0]};
      default: rdata_fmt = rdata_shifted;
    endcase
  end

  always_comb begin
    case (size_q)
      2'd0:    wstrb_raw = 4'b0001 << addr_q[1:0];
      2'd1:    wstrb_raw = 4'b0011 << addr_q[1:0];
      default: wstrb_raw = 4'b1111;
    endcase
  end

  // State and captured request
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= 2'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      resp_q    <= 2'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next state; LIMP inputs are only looked at in IDLE
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (i_limp_valid) begin
          addr_d    = i_limp_addr;
          size_d    = i_limp_size;
          wdata_d   = i_limp_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = i_limp_wen_nren ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: if (i_arready) state_d = RD_DATA;
      RD_DATA: begin
        if (i_rvalid) begin
          rdata_d = i_rdata;
          resp_d  = i_rresp;
          state_d = DONE;
        end
      end
      WR_REQ: begin
        // AW and W complete independently, in either order or together
        aw_done_d = aw_done_q | i_awready;
        w_done_d  = w_done_q | i_wready;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (i_bvalid) begin
          resp_d  = i_bresp;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_arvalid    = 1'b0;
    o_araddr     = '0;
    o_rready     = 1'b0;
    o_awvalid    = 1'b0;
    o_awaddr     = '0;
    o_wvalid     = 1'b0;
    o_wdata      = 32'd0;
    o_wstrb      = 4'd0;
    o_bready     = 1'b0;
    o_limp_ready = 1'b0;
    o_limp_rdata = 32'd0;
    o_bus_error  = 1'b0;
    case (state_q)
      RD_ADDR: begin
        o_arvalid = 1'b1;
        o_araddr  = addr_aligned;
      end
      RD_DATA: o_rready = 1'b1;
      WR_REQ: begin
        o_awvalid = !aw_done_q;
        o_wvalid  = !w_done_q;
        o_awaddr  = addr_aligned;
        o_wdata   = wdata_q << lane_shift;
        o_wstrb   = wstrb_raw;
      end
      WR_RESP: o_bready = 1'b1;
      DONE: begin
        o_limp_ready = 1'b1;
        o_limp_rdata = rdata_fmt;
        o_bus_error  = (resp_q != 2'b00);
      end
      default: ;
    endcase
  end

  // Misaligned halfword/word and size 3 have no defined behaviour
  a_legal_req: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state_q == IDLE && i_limp_valid) |->
      (i_limp_size != 2'd3) &&
      !(i_limp_size == 2'd1 && i_limp_addr[0]) &&
      !(i_limp_size == 2'd2 && i_limp_addr[1:0] != 2'b00));

endmodule

// File: tb/tb_letc_core_limp_axi_bridge.sv
// Bench for the LIMP-to-AXI bridge: table of single transactions against a delay-programmable
// AXI slave, plus hand sequences for back-to-back requests and reset in the middle of a write.
`timescale 1ns/1ps
module tb_letc_core_limp_axi_bridge;
  localparam int PADDR_W = 34;
  localparam int NVEC    = 10;

  logic               i_clk = 1'b0;
  logic               i_rst_n = 1'b0;
  logic               i_limp_valid = 1'b0;
  logic               o_limp_ready;
  logic               i_limp_wen_nren = 1'b0;
  logic               i_limp_uncacheable = 1'b0;
  logic [1:0]         i_limp_size = 2'd0;
  logic [PADDR_W-1:0] i_limp_addr = '0;
  logic [31:0]        o_limp_rdata;
  logic [31:0]        i_limp_wdata = 32'd0;
  logic               o_awvalid, i_awready = 1'b0;
  logic [PADDR_W-1:0] o_awaddr;
  logic               o_wvalid, i_wready = 1'b0;
  logic [31:0]        o_wdata;
  logic [3:0]         o_wstrb;
  logic               i_bvalid = 1'b0, o_bready;
  logic [1:0]         i_bresp = 2'd0;
  logic               o_arvalid, i_arready = 1'b0;
  logic [PADDR_W-1:0] o_araddr;
  logic               i_rvalid = 1'b0, o_rready;
  logic [31:0]        i_rdata = 32'd0;
  logic [1:0]         i_rresp = 2'd0;
  logic               o_bus_error;

  always #5 i_clk = ~i_clk;

  letc_core_limp_axi_bridge #(.PADDR_W(PADDR_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_limp_valid(i_limp_valid), .o_limp_ready(o_limp_ready),
    .i_limp_wen_nren(i_limp_wen_nren), .i_limp_uncacheable(i_limp_uncacheable),
    .i_limp_size(i_limp_size), .i_limp_addr(i_limp_addr),
    .o_limp_rdata(o_limp_rdata), .i_limp_wdata(i_limp_wdata),
    .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr),
    .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata), .o_wstrb(o_wstrb),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata), .i_rresp(i_rresp),
    .o_bus_error(o_bus_error)
  );

  typedef struct {
    logic               wen;
    logic [1:0]         size;
    logic [PADDR_W-1:0] addr;
    logic [31:0]        wdata;
    logic [31:0]        srdata;
    logic [1:0]         resp;
    int                 aw_dly, w_dly, ar_dly, r_dly, b_dly;
    logic [PADDR_W-1:0] exp_addr;
    logic [31:0]        exp_wdata;
    logic [3:0]         exp_wstrb;
    logic [31:0]        exp_rdata;
    logic               exp_err;
  } vec_t;

  vec_t vecs[NVEC];
  vec_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(input logic wen, input logic [1:0] size,
                              input logic [PADDR_W-1:0] addr, input logic [31:0] wdata,
                              input logic [31:0] srdata, input logic [1:0] resp,
                              input int aw_dly, input int w_dly, input int ar_dly,
                              input int r_dly, input int b_dly,
                              input logic [PADDR_W-1:0] exp_addr, input logic [31:0] exp_wdata,
                              input logic [3:0] exp_wstrb, input logic [31:0] exp_rdata,
                              input logic exp_err);
    vec_t v;
    v.wen = wen; v.size = size; v.addr = addr; v.wdata = wdata; v.srdata = srdata;
    v.resp = resp; v.aw_dly = aw_dly; v.w_dly = w_dly; v.ar_dly = ar_dly;
    v.r_dly = r_dly; v.b_dly = b_dly; v.exp_addr = exp_addr; v.exp_wdata = exp_wdata;
    v.exp_wstrb = exp_wstrb; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   cyc, rdy_cyc, rdy_n, aw_n, w_n, ar_n, exp_lat;
    int   aw_wait, w_wait, ar_wait, r_wait, b_wait;
    logic aw_ok, w_ok, ar_ok, r_ok, b_ok;
    vec_t e;
    rdy_cyc = -1; rdy_n = 0; aw_n = 0; w_n = 0; ar_n = 0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 0; b_wait = 0;
    aw_ok = 0; w_ok = 0; ar_ok = 0; r_ok = 0; b_ok = 0;
    exp_lat = v.wen ? 3 + ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) + v.b_dly
                    : 3 + v.ar_dly + v.r_dly;
    @(negedge i_clk);
    i_limp_valid = 1'b1; i_limp_wen_nren = v.wen; i_limp_size = v.size;
    i_limp_addr = v.addr; i_limp_wdata = v.wdata; i_limp_uncacheable = 1'($urandom);
    sb_q.push_back(v);
    cyc = 0;
    while (cyc < 80 && (rdy_cyc < 0 || cyc <= rdy_cyc)) begin
      if (cyc >= 1 && rdy_cyc < 0) begin
        // captured values must govern; scribble on the live request
        i_limp_addr = PADDR_W'($urandom); i_limp_wdata = $urandom;
        i_limp_size = 2'($urandom); i_limp_wen_nren = ~v.wen;
      end
      i_arready = o_arvalid && (ar_wait >= v.ar_dly);
      i_awready = o_awvalid && (aw_wait >= v.aw_dly);
      i_wready  = o_wvalid && (w_wait >= v.w_dly);
      i_rvalid  = ar_ok && !r_ok && (r_wait >= v.r_dly);
      i_rdata   = v.srdata;
      i_rresp   = i_rvalid ? v.resp : 2'b00;
      i_bvalid  = aw_ok && w_ok && !b_ok && (b_wait >= v.b_dly);
      i_bresp   = i_bvalid ? v.resp : 2'b00;
      if (o_arvalid && !i_arready) ar_wait++;
      if (o_awvalid && !i_awready) aw_wait++;
      if (o_wvalid && !i_wready) w_wait++;
      if (ar_ok && !r_ok && !i_rvalid) r_wait++;
      if (aw_ok && w_ok && !b_ok && !i_bvalid) b_wait++;
      if (o_arvalid && i_arready) begin
        ar_n++; ar_ok = 1;
        chk($sformatf("v%0d_araddr", idx), 64'(o_araddr), 64'(v.exp_addr));
      end
      if (o_awvalid && i_awready) begin
        aw_n++; aw_ok = 1;
        chk($sformatf("v%0d_awaddr", idx), 64'(o_awaddr), 64'(v.exp_addr));
      end
      if (o_wvalid && i_wready) begin
        w_n++; w_ok = 1;
        chk($sformatf("v%0d_wdata", idx), 64'(o_wdata), 64'(v.exp_wdata));
        chk($sformatf("v%0d_wstrb", idx), 64'(o_wstrb), 64'(v.exp_wstrb));
      end
      if (o_rready && i_rvalid) r_ok = 1;
      if (o_bready && i_bvalid) b_ok = 1;
      if (o_limp_ready) begin
        rdy_n++;
        if (rdy_cyc < 0 && sb_q.size() > 0) begin
          rdy_cyc = cyc;
          e = sb_q.pop_front();
          if (!e.wen) chk($sformatf("v%0d_rdata", idx), 64'(o_limp_rdata), 64'(e.exp_rdata));
          chk($sformatf("v%0d_bus_error", idx), 64'(o_bus_error), 64'(e.exp_err));
          chk($sformatf("v%0d_latency", idx), 64'(cyc), 64'(exp_lat));
          i_limp_valid = 1'b0;
        end
      end
      @(negedge i_clk);
      cyc++;
    end
    i_arready = 0; i_awready = 0; i_wready = 0; i_rvalid = 0; i_bvalid = 0;
    i_limp_valid = 1'b0;
    if (rdy_cyc < 0 && sb_q.size() > 0) e = sb_q.pop_front();
    chk($sformatf("v%0d_ready_pulses", idx), 64'(rdy_n), 64'd1);
    chk($sformatf("v%0d_ready_width", idx), 64'(o_limp_ready), 64'd0);
    chk($sformatf("v%0d_hs_counts", idx), 64'({aw_n[3:0], w_n[3:0], ar_n[3:0]}),
        v.wen ? 64'h110 : 64'h001);
    $display("txn %0d %s size=%0d addr=0x%0h ready_cycle=%0d rdata=0x%08h",
             idx, v.wen ? "WR" : "RD", v.size, v.addr, rdy_cyc, e.exp_rdata);
  endtask

  initial begin
    int   ar_n, first, second, pulses, viol, k;
    vec_t e;

    vecs[0] = mk(0, 2, 34'h0ABCD1234, 32'h0, 32'h12345678, 2'b00, 0, 0, 0, 0, 0,
                 34'h0ABCD1234, 32'h0, 4'h0, 32'h12345678, 0);
    vecs[1] = mk(0, 0, 34'h0ABCD1233, 32'h0, 32'hAABBCCDD, 2'b00, 0, 0, 0, 0, 0,
                 34'h0ABCD1230, 32'h0, 4'h0, 32'h000000AA, 0);
    vecs[2] = mk(0, 1, 34'h0ABCD1202, 32'h0, 32'hAABBCCDD, 2'b00, 0, 0, 1, 1, 0,
                 34'h0ABCD1200, 32'h0, 4'h0, 32'h0000AABB, 0);
    vecs[3] = mk(0, 0, 34'h0ABCD1201, 32'h0, 32'hAABBCCDD, 2'b00, 0, 0, 0, 0, 0,
                 34'h0ABCD1200, 32'h0, 4'h0, 32'h000000CC, 0);
    vecs[4] = mk(0, 2, 34'h0ABCD1100, 32'h0, 32'hDEADBEEF, 2'b10, 0, 0, 0, 5, 0,
                 34'h0ABCD1100, 32'h0, 4'h0, 32'hDEADBEEF, 1);
    vecs[5] = mk(1, 1, 34'h0ABCD1202, 32'h3C3CA5A5, 32'h0, 2'b00, 0, 3, 0, 0, 0,
                 34'h0ABCD1200, 32'hA5A50000, 4'b1100, 32'h0, 0);
    vecs[6] = mk(1, 1, 34'h0ABCD1202, 32'h3C3CA5A5, 32'h0, 2'b00, 0, 0, 0, 0, 0,
                 34'h0ABCD1200, 32'hA5A50000, 4'b1100, 32'h0, 0);
    vecs[7] = mk(1, 0, 34'h0ABCD1003, 32'h123456EE, 32'h0, 2'b00, 2, 0, 0, 0, 2,
                 34'h0ABCD1000, 32'hEE000000, 4'b1000, 32'h0, 0);
    vecs[8] = mk(1, 2, 34'h300000010, 32'hCAFEF00D, 32'h0, 2'b11, 1, 1, 0, 0, 2,
                 34'h300000010, 32'hCAFEF00D, 4'b1111, 32'h0, 1);
    vecs[9] = mk(0, 1, 34'h0ABCD0000, 32'h0, 32'h89AB7654, 2'b00, 0, 0, 2, 0, 0,
                 34'h0ABCD0000, 32'h0, 4'h0, 32'h00007654, 0);

    #1;
    chk("reset_ctrl", 64'({o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready,
                          o_limp_ready, o_bus_error}), 64'd0);
    chk("reset_data", 64'({o_wstrb, o_wdata, o_limp_rdata}), 64'd0);
    chk("reset_addr", 64'(o_araddr | o_awaddr), 64'd0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    viol = 0;
    for (k = 0; k < 3; k++) begin
      @(negedge i_clk);
      if (o_arvalid || o_awvalid || o_wvalid || o_limp_ready) viol++;
    end
    chk("idle_after_reset", 64'(viol), 64'd0);

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // Back-to-back: valid held high across the first completion
    @(negedge i_clk);
    i_limp_valid = 1'b1; i_limp_wen_nren = 1'b0; i_limp_size = 2'd2;
    i_limp_addr = 34'h0ABCD1234; i_rdata = 32'h12345678; i_arready = 1'b1;
    sb_q.push_back(vecs[0]); sb_q.push_back(vecs[0]);
    ar_n = 0; first = -1; second = -1; pulses = 0;
    for (int c = 0; c < 8; c++) begin
      i_rvalid = o_rready; i_rresp = 2'b00;
      if (o_arvalid && i_arready) ar_n++;
      if (o_limp_ready) begin
        pulses++;
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("b2b_rdata", 64'(o_limp_rdata), 64'(e.exp_rdata));
        end
        if (first < 0) first = c; else second = c;
      end
      @(negedge i_clk);
    end
    i_limp_valid = 1'b0; i_arready = 1'b0; i_rvalid = 1'b0;
    sb_q.delete();
    repeat (2) @(negedge i_clk);
    chk("b2b_ar_count", 64'(ar_n), 64'd2);
    chk("b2b_pulses", 64'(pulses), 64'd2);
    chk("b2b_gap_ge2", 64'((second - first) >= 2 && first >= 0 && second > 0), 64'd1);
    $display("txn b2b ar_handshakes=%0d ready_cycles=%0d,%0d", ar_n, first, second);

    // Reset while waiting for the write response
    @(negedge i_clk);
    i_limp_valid = 1'b1; i_limp_wen_nren = 1'b1; i_limp_size = 2'd2;
    i_limp_addr = 34'h000000010; i_limp_wdata = 32'h55AA55AA;
    i_awready = 1'b1; i_wready = 1'b1;
    for (k = 0; k < 10 && !o_bready; k++) @(negedge i_clk);
    chk("rst_bready_reached", 64'(o_bready), 64'd1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", 64'({o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready,
                            o_limp_ready, o_bus_error}), 64'd0);
    chk("rst_mid_data", 64'({o_wstrb, o_wdata, o_limp_rdata}), 64'd0);
    i_limp_valid = 1'b0; i_awready = 1'b0; i_wready = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    viol = 0;
    for (k = 0; k < 6; k++) begin
      @(negedge i_clk);
      if (o_arvalid || o_awvalid || o_wvalid || o_bready || o_rready || o_limp_ready) viol++;
    end
    chk("rst_mid_quiet", 64'(viol), 64'd0);
    $display("txn reset_mid_write quiet_violations=%0d", viol);

    run_vec(NVEC, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end
endmodule
